// File: rtl/vin_quadencoder_idx.sv
// Quadrature encoder front end: per-pin synchroniser and glitch filter, 4x decode,
// index capture with enable/done handshake, and a sticky illegal-transition flag.
module vin_quadencoder_idx #(
    parameter int WIDTH          = 32,
    parameter int FILTER         = 3,
    parameter int INVERT         = 0,
    parameter int RESET_ON_INDEX = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             quadA,
    input  logic             quadB,
    input  logic             quadZ,
    input  logic             index_enable,
    input  logic             err_clear,
    output logic [WIDTH-1:0] pos,
    output logic [WIDTH-1:0] index_pos,
    output logic             index_done,
    output logic             err
);

    localparam logic [7:0] FILTER_LAST = 8'(FILTER - 1);

    logic [2:0] pins_raw;
    logic [2:0] filt_w;

    assign pins_raw = {quadA, quadB, quadZ};

    // Bit 2 = A, bit 1 = B, bit 0 = Z; each pin gets its own sync pair and filter.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_filt
            logic       s1_reg;
            logic       s2_reg;
            logic       filt_reg;
            logic [7:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg   <= 1'b0;
                    s2_reg   <= 1'b0;
                    filt_reg <= 1'b0;
                    cnt_reg  <= '0;
                end else begin
                    s1_reg <= pins_raw[gi];
                    s2_reg <= s1_reg;
                    if (s2_reg == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == FILTER_LAST) begin
                        filt_reg <= s2_reg;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
            end

            assign filt_w[gi] = filt_reg;
        end
    endgenerate

    logic [1:0]       prev_ab_reg;
    logic             prev_z_reg;
    logic [WIDTH-1:0] pos_reg;
    logic [WIDTH-1:0] index_pos_reg;
    logic             index_done_reg;
    logic             err_reg;

    logic [1:0]       cur_ab;
    logic             fwd;
    logic             rev;
    logic             illegal;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] pos_next;
    logic             index_event;

    assign cur_ab = filt_w[2:1];

    always_comb begin
        fwd = ((prev_ab_reg == 2'b00) && (cur_ab == 2'b10)) ||
              ((prev_ab_reg == 2'b10) && (cur_ab == 2'b11)) ||
              ((prev_ab_reg == 2'b11) && (cur_ab == 2'b01)) ||
              ((prev_ab_reg == 2'b01) && (cur_ab == 2'b00));
        rev = ((prev_ab_reg == 2'b00) && (cur_ab == 2'b01)) ||
              ((prev_ab_reg == 2'b01) && (cur_ab == 2'b11)) ||
              ((prev_ab_reg == 2'b11) && (cur_ab == 2'b10)) ||
              ((prev_ab_reg == 2'b10) && (cur_ab == 2'b00));
        illegal = ((prev_ab_reg ^ cur_ab) == 2'b11);
        inc = (INVERT != 0) ? rev : fwd;
        dec = (INVERT != 0) ? fwd : rev;
        // A -1 step is all ones so a single adder covers both directions with wrap.
        if (inc) begin
            step = WIDTH'(1);
        end else if (dec) begin
            step = '1;
        end else begin
            step = '0;
        end
        pos_next    = pos_reg + step;
        index_event = filt_w[0] && !prev_z_reg && index_enable && !index_done_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ab_reg    <= 2'b00;
            prev_z_reg     <= 1'b0;
            pos_reg        <= '0;
            index_pos_reg  <= '0;
            index_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            prev_ab_reg <= cur_ab;
            prev_z_reg  <= filt_w[0];
            if (index_event) begin
                index_pos_reg  <= pos_next;
                index_done_reg <= 1'b1;
                pos_reg        <= (RESET_ON_INDEX != 0) ? '0 : pos_next;
            end else begin
                pos_reg <= pos_next;
                if (!index_enable) begin
                    index_done_reg <= 1'b0;
                end
            end
            // Setting has priority so a same-cycle clear cannot hide a new fault.
            if (illegal) begin
                err_reg <= 1'b1;
            end else if (err_clear) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign pos        = pos_reg;
    assign index_pos  = index_pos_reg;
    assign index_done = index_done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_vin_quadencoder_idx.sv
// Bench for vin_quadencoder_idx: two instances (32-bit reset-on-index, 8-bit inverted latch-only)
// share the pins and are compared against step-level position models.
module tb_vin_quadencoder_idx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        quadA = 1'b0;
    logic        quadB = 1'b0;
    logic        quadZ = 1'b0;
    logic        index_enable = 1'b0;
    logic        err_clear = 1'b0;

    logic [31:0] pos0, idx0;
    logic        done0, err0;
    logic [7:0]  pos1, idx1;
    logic        done1, err1;

    logic [31:0] m_pos0, m_idx0;
    logic [7:0]  m_pos1, m_idx1;
    logic        m_done;
    int          phase;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    vin_quadencoder_idx #(.WIDTH(32), .FILTER(3), .INVERT(0), .RESET_ON_INDEX(1)) u0 (
        .clk(clk), .rst_n(rst_n), .quadA(quadA), .quadB(quadB), .quadZ(quadZ),
        .index_enable(index_enable), .err_clear(err_clear),
        .pos(pos0), .index_pos(idx0), .index_done(done0), .err(err0)
    );

    vin_quadencoder_idx #(.WIDTH(8), .FILTER(3), .INVERT(1), .RESET_ON_INDEX(0)) u1 (
        .clk(clk), .rst_n(rst_n), .quadA(quadA), .quadB(quadB), .quadZ(quadZ),
        .index_enable(index_enable), .err_clear(err_clear),
        .pos(pos1), .index_pos(idx1), .index_done(done1), .err(err1)
    );

    // Forward quadrature cycle for {A,B}: 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] ab_of(input int p);
        case (p)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic quad_step(input int dir, input int hold);
        @(negedge clk);
        phase = (phase + dir + 4) % 4;
        {quadA, quadB} = ab_of(phase);
        m_pos0 = m_pos0 + 32'(dir);
        m_pos1 = m_pos1 - 8'(dir);
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic goto0(input logic [31:0] tgt);
        while (m_pos0 != tgt) quad_step(($signed(m_pos0) < $signed(tgt)) ? 1 : -1, 6);
    endtask

    task automatic goto1(input logic [7:0] tgt);
        while (m_pos1 != tgt) quad_step(-1, 6);
    endtask

    task automatic set_enable(input logic v);
        @(negedge clk);
        index_enable = v;
        @(posedge clk);
        #1;
        if (!v) m_done = 1'b0;
    endtask

    task automatic z_pulse();
        @(negedge clk);
        quadZ = 1'b1;
        if (index_enable && !m_done) begin
            m_idx0 = m_pos0;
            m_pos0 = '0;
            m_idx1 = m_pos1;
            m_done = 1'b1;
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        quadZ = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pos0, idx0, done0, err0, pos1, idx1, done1, err1} !== '0)
            $display("FAIL reset_held: got pos0=%h idx0=%h done0=%b err0=%b pos1=%h, expected all 0",
                     pos0, idx0, done0, err0, pos1);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pos0, idx0, done0, err0, pos1, idx1, done1, err1} !== '0)
            $display("FAIL reset_release: got pos0=%h pos1=%h err0=%b, expected all 0", pos0, pos1, err0);
        else passed++;
        $display("reset: pos0=%h pos1=%h", pos0, pos1);
    endtask

    task automatic test_forward();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            phase = (phase + 1) % 4;
            {quadA, quadB} = ab_of(phase);
            repeat (5) @(posedge clk);
            #1;
            checks++;
            if (pos0 !== m_pos0)
                $display("FAIL fwd_early%0d: got pos0=%h, expected %h before edge k+5", i, pos0, m_pos0);
            else passed++;
            m_pos0 = m_pos0 + 32'd1;
            m_pos1 = m_pos1 - 8'd1;
            @(posedge clk);
            #1;
            checks++;
            if ({pos0, pos1, err0} !== {32'(i + 1), m_pos1, 1'b0})
                $display("FAIL fwd_step%0d: got pos0=%h pos1=%h err=%b, expected %h %h 0",
                         i, pos0, pos1, err0, 32'(i + 1), m_pos1);
            else passed++;
            $display("forward step %0d: pos0=%h pos1=%h", i, pos0, pos1);
            repeat (14) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reverse();
        for (int i = 0; i < 4; i++) quad_step(-1, 8);
        checks++;
        if ({pos0, pos1} !== {32'd0, 8'd0})
            $display("FAIL rev_to_zero: got pos0=%h pos1=%h, expected 0 0", pos0, pos1);
        else passed++;
        quad_step(-1, 8);
        checks++;
        if ({pos0, pos1} !== {32'hFFFF_FFFF, 8'd1})
            $display("FAIL rev_wrap: got pos0=%h pos1=%h, expected ffffffff 01", pos0, pos1);
        else passed++;
        $display("reverse: pos0=%h pos1=%h", pos0, pos1);
    endtask

    task automatic test_glitch();
        @(negedge clk);
        quadA = ~quadA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        quadA = ~quadA;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({pos0, pos1, err0} !== {m_pos0, m_pos1, 1'b0})
            $display("FAIL glitch: got pos0=%h pos1=%h err=%b, expected %h %h 0", pos0, pos1, err0, m_pos0, m_pos1);
        else passed++;
        $display("glitch: pos0=%h", pos0);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        quadA = ~quadA;
        quadB = ~quadB;
        phase = (phase + 2) % 4;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({pos0, pos1, err0, err1} !== {m_pos0, m_pos1, 2'b11})
            $display("FAIL illegal: got pos0=%h pos1=%h err=%b%b, expected %h %h 11",
                     pos0, pos1, err0, err1, m_pos0, m_pos1);
        else passed++;
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        checks++;
        if ({err0, err1} !== 2'b00) $display("FAIL err_clear: got err=%b%b, expected 00", err0, err1);
        else passed++;
        // Illegal pair first sampled at edge k is decoded at k+5; clear lands on that edge.
        @(negedge clk);
        quadA = ~quadA;
        quadB = ~quadB;
        phase = (phase + 2) % 4;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (err0 !== 1'b0) $display("FAIL err_early: got err=%b, expected 0", err0);
        else passed++;
        @(negedge clk);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({err0, err1} !== 2'b11) $display("FAIL err_set_wins: got err=%b%b, expected 11", err0, err1);
        else passed++;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        $display("illegal: pos0=%h err=%b", pos0, err0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op < 2) begin
                quad_step(op == 0 ? 1 : -1, $urandom_range(6, 12));
            end else if (op == 2) begin
                int len;
                logic chan;
                len = $urandom_range(1, 2);
                chan = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (chan) quadA = ~quadA; else quadB = ~quadB;
                repeat (len) @(posedge clk);
                @(negedge clk);
                if (chan) quadA = ~quadA; else quadB = ~quadB;
                repeat (6) @(posedge clk);
                #1;
            end else begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
            end
            checks++;
            if ({pos0, pos1, err0} !== {m_pos0, m_pos1, 1'b0})
                $display("FAIL random%0d op%0d: got pos0=%h pos1=%h err=%b, expected %h %h 0",
                         i, op, pos0, pos1, err0, m_pos0, m_pos1);
            else passed++;
            $display("random %0d op %0d: pos0=%h pos1=%h", i, op, pos0, pos1);
        end
    endtask

    task automatic test_index_reset();
        goto0(32'd37);
        set_enable(1'b1);
        z_pulse();
        checks++;
        if ({idx0, pos0, done0} !== {32'd37, 32'd0, 1'b1})
            $display("FAIL index_capture: got idx=%h pos=%h done=%b, expected 00000025 0 1", idx0, pos0, done0);
        else passed++;
        checks++;
        if ({idx1, pos1, done1} !== {m_idx1, m_pos1, 1'b1})
            $display("FAIL index_latch_only: got idx1=%h pos1=%h done1=%b, expected %h %h 1",
                     idx1, pos1, done1, m_idx1, m_pos1);
        else passed++;
        quad_step(1, 6);
        z_pulse();
        checks++;
        if ({idx0, pos0, done0} !== {32'd37, 32'd1, 1'b1})
            $display("FAIL index_second: got idx=%h pos=%h done=%b, expected 00000025 1 1", idx0, pos0, done0);
        else passed++;
        @(negedge clk);
        index_enable = 1'b0;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        checks++;
        if ({done0, done1} !== 2'b00) $display("FAIL done_clear: got done=%b%b, expected 00", done0, done1);
        else passed++;
        $display("index reset: idx0=%h pos0=%h", idx0, pos0);
    endtask

    task automatic test_index_disabled();
        z_pulse();
        checks++;
        if ({idx0, pos0, idx1, pos1, done0} !== {m_idx0, m_pos0, m_idx1, m_pos1, 1'b0})
            $display("FAIL index_disabled: got idx0=%h pos0=%h idx1=%h done=%b, expected %h %h %h 0",
                     idx0, pos0, idx1, done0, m_idx0, m_pos0, m_idx1);
        else passed++;
        $display("index disabled: idx0=%h pos0=%h", idx0, pos0);
    endtask

    task automatic test_index_coincide();
        goto1(8'd12);
        set_enable(1'b1);
        @(negedge clk);
        quadZ = 1'b1;
        phase = (phase + 3) % 4;
        {quadA, quadB} = ab_of(phase);
        m_idx0 = m_pos0 - 32'd1;
        m_pos0 = '0;
        m_pos1 = m_pos1 + 8'd1;
        m_done = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        quadZ = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if ({idx1, pos1, done1} !== {8'd13, 8'd13, 1'b1})
            $display("FAIL coincide_latch: got idx1=%h pos1=%h done1=%b, expected 0d 0d 1", idx1, pos1, done1);
        else passed++;
        checks++;
        if ({idx0, pos0} !== {m_idx0, m_pos0})
            $display("FAIL coincide_reset: got idx0=%h pos0=%h, expected %h %h", idx0, pos0, m_idx0, m_pos0);
        else passed++;
        set_enable(1'b0);
        $display("index coincide: idx1=%h pos1=%h", idx1, pos1);
    endtask

    task automatic test_wrap8();
        goto1(8'h7F);
        quad_step(-1, 6);
        checks++;
        if ({pos0, pos1} !== {m_pos0, 8'h80})
            $display("FAIL wrap8: got pos0=%h pos1=%h, expected %h 80", pos0, pos1, m_pos0);
        else passed++;
        $display("wrap8: pos1=%h", pos1);
    endtask

    task automatic test_async_reset();
        goto0(32'd100);
        checks++;
        if (pos0 !== 32'd100) $display("FAIL pre_reset: got pos0=%h, expected 00000064", pos0);
        else passed++;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pos0, idx0, done0, err0, pos1, idx1, done1, err1} !== '0)
            $display("FAIL async_reset: got pos0=%h idx0=%h pos1=%h idx1=%h, expected all 0",
                     pos0, idx0, pos1, idx1);
        else passed++;
        quadA = 1'b0;
        quadB = 1'b0;
        quadZ = 1'b0;
        phase = 0;
        m_pos0 = '0;
        m_pos1 = '0;
        m_idx0 = '0;
        m_idx1 = '0;
        m_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        quad_step(1, 6);
        checks++;
        if ({pos0, pos1, err0} !== {32'd1, 8'hFF, 1'b0})
            $display("FAIL post_reset_step: got pos0=%h pos1=%h err=%b, expected 1 ff 0", pos0, pos1, err0);
        else passed++;
        $display("async reset: pos0=%h pos1=%h", pos0, pos1);
    endtask

    initial begin
        m_pos0 = '0;
        m_pos1 = '0;
        m_idx0 = '0;
        m_idx1 = '0;
        m_done = 1'b0;
        phase  = 0;
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_random();
        test_index_reset();
        test_index_disabled();
        test_index_coincide();
        test_wrap8();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
